// File: rtl/pc_interface_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_interface_pkg
// Brief    : Shared types and constants for the PC interface blocks.
// Revision : 1.0 - initial release
// ============================================================================
package pc_interface_pkg;

    localparam int unsigned c_TX_BYTE_WIDTH = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_t;

endpackage : pc_interface_pkg
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_picker
// Brief    : Combinational round-robin pick; one-hot grant to the first
//            request at or after the pointer, wrapping modulo NUM_REQ.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_picker #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned PTR_WIDTH = 1
) (
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [PTR_WIDTH-1:0] i_ptr,
    output logic [NUM_REQ-1:0]   o_grant
);

    logic [PTR_WIDTH-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        o_grant = '0;
        w_idx   = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            w_idx = PTR_WIDTH'((32'(i_ptr) + 32'(i)) % NUM_REQ);
            if (i_req[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
            end
        end
    end

endmodule : rr_priority_picker
`default_nettype wire

// File: rtl/pc_interface_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pc_interface_tx_arbiter
// Brief    : Frame-level round-robin arbiter sharing the UART TX byte channel,
//            with a mid-frame stall timeout.
// Revision : 1.0 - initial release
// ============================================================================
module pc_interface_tx_arbiter
    import pc_interface_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned DATA_WIDTH    = c_TX_BYTE_WIDTH,
    parameter int unsigned TIMEOUT_WIDTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ-1:0]            i_req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic                          i_tx_rdy,
    output logic                          o_tx_wr,
    output logic [DATA_WIDTH-1:0]         o_tx_data,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_busy,
    output logic                          o_timeout
);

    localparam int unsigned c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Timeout fires on the idle cycle that would bring the count to all-ones.
    localparam logic [TIMEOUT_WIDTH-1:0] c_STALL_FIRE = {TIMEOUT_WIDTH{1'b1}} - 1'b1;

    arb_state_t               r_state, w_state_nxt;
    logic [NUM_REQ-1:0]       r_grant, w_grant_nxt, w_pick;
    logic [c_PTR_W-1:0]       r_ptr, w_ptr_nxt, w_owner_idx, w_ptr_after;
    logic [TIMEOUT_WIDTH-1:0] r_stall, w_stall_nxt;
    logic [DATA_WIDTH-1:0]    w_own_data;
    logic                     w_own_valid, w_own_last, w_hs;

    rr_priority_picker #(
        .NUM_REQ   (NUM_REQ),
        .PTR_WIDTH (c_PTR_W)
    ) u_picker (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick)
    );

    assign w_own_valid = |(i_req_valid & r_grant);
    assign w_own_last  = |(i_req_last & r_grant);
    assign w_hs        = (r_state == ST_XFER) & w_own_valid & i_tx_rdy;
    assign w_ptr_after = (w_owner_idx == c_PTR_W'(NUM_REQ - 1)) ? '0 : w_owner_idx + 1'b1;
    assign o_grant     = r_grant;
    assign o_busy      = (r_state == ST_XFER);

    always_comb begin
        w_owner_idx = '0;
        w_own_data  = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (r_grant[k]) begin
                w_owner_idx = c_PTR_W'(k);
                w_own_data  = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_stall_nxt = r_stall;
        o_req_ready = '0;
        o_tx_wr     = 1'b0;
        o_tx_data   = '0;
        o_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall_nxt = '0;
                if (|i_req_valid) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                o_tx_data = w_own_data;
                o_tx_wr   = w_hs;
                if (!w_own_valid && (r_stall == c_STALL_FIRE)) begin
                    o_timeout   = 1'b1;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = w_ptr_after;
                    w_stall_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    o_req_ready = r_grant & {NUM_REQ{i_tx_rdy}};
                    if (w_hs) begin
                        w_stall_nxt = '0;
                        if (w_own_last) begin
                            w_grant_nxt = '0;
                            w_ptr_nxt   = w_ptr_after;
                            w_state_nxt = ST_IDLE;
                        end
                    end else if (!w_own_valid) begin
                        // Backpressure with valid held is not a stall.
                        w_stall_nxt = r_stall + 1'b1;
                    end
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_stall <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_stall <= w_stall_nxt;
        end
    end

endmodule : pc_interface_tx_arbiter
`default_nettype wire

// File: tb/tb_pc_interface_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_interface_tx_arbiter
// Brief    : Directed and random stimulus against a behavioural arbiter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_interface_tx_arbiter;

    localparam int NR          = 2;
    localparam int DW          = 8;
    localparam int TW          = 4;
    localparam int STALL_LIMIT = (1 << TW) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid, req_last, req_ready, grant;
    logic [NR*DW-1:0] req_data;
    logic             tx_rdy, tx_wr, busy, timeout;
    logic [DW-1:0]    tx_data;

    always #5 clk = ~clk;

    pc_interface_tx_arbiter #(
        .NUM_REQ       (NR),
        .DATA_WIDTH    (DW),
        .TIMEOUT_WIDTH (TW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_last  (req_last),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .i_tx_rdy    (tx_rdy),
        .o_tx_wr     (tx_wr),
        .o_tx_data   (tx_data),
        .o_grant     (grant),
        .o_busy      (busy),
        .o_timeout   (timeout)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    // Model: owner (-1 when idle), rotation pointer, consecutive idle cycles of owner.
    int m_owner  = -1;
    int m_ptr    = 0;
    int m_idle   = 0;
    int last_wr_t = 0;
    int tmo_gap   = -1;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    bit mute0 = 1'b0;
    bit mute1 = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic push(input int k, input int len, input logic [7:0] base, input bit close);
        logic [8:0] e;
        for (int i = 0; i < len; i++) begin
            e = {(close && (i == len - 1)), base + 8'(i)};
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic step();
        logic [8:0]    h0, h1;
        logic [NR-1:0] e_grant, e_ready;
        bit            ov, tmo, wr_e, found;
        int            o, n_owner, n_ptr, n_idle, acc, k;
        h0 = (q0.size() > 0) ? q0[0] : 9'h000;
        h1 = (q1.size() > 0) ? q1[0] : 9'h000;
        req_valid[0] = (q0.size() > 0) && !mute0;
        req_valid[1] = (q1.size() > 0) && !mute1;
        req_last     = {h1[8], h0[8]};
        req_data     = {h1[7:0], h0[7:0]};
        @(negedge clk);
        o = m_owner; ov = 1'b0; tmo = 1'b0; wr_e = 1'b0;
        e_grant = '0; e_ready = '0;
        if (o >= 0) begin
            ov      = req_valid[o];
            tmo     = !ov && (m_idle + 1 == STALL_LIMIT);
            wr_e    = ov && tx_rdy;
            e_grant = NR'(1 << o);
            e_ready = (!tmo && tx_rdy) ? NR'(1 << o) : '0;
        end
        check("grant",   32'(grant),     32'(e_grant));
        check("busy",    32'(busy),      32'(o >= 0));
        check("ready",   32'(req_ready), 32'(e_ready));
        check("tx_wr",   32'(tx_wr),     32'(wr_e));
        check("timeout", 32'(timeout),   32'(tmo));
        if (wr_e) check("tx_data", 32'(tx_data), 32'(req_data[o*DW +: DW]));
        if (timeout) tmo_gap = cyc - last_wr_t;
        if (tx_wr) last_wr_t = cyc;
        n_owner = m_owner; n_ptr = m_ptr; n_idle = m_idle;
        if (rst) begin
            n_owner = -1; n_ptr = 0; n_idle = 0;
        end else if (o < 0) begin
            found = 1'b0;
            for (int i = 0; i < NR; i++) begin
                k = (m_ptr + i) % NR;
                if (!found && req_valid[k]) begin
                    found = 1'b1; n_owner = k; n_idle = 0;
                end
            end
        end else if (tmo) begin
            n_owner = -1; n_ptr = (o + 1) % NR; n_idle = 0;
        end else if (wr_e) begin
            n_idle = 0;
            if (req_last[o]) begin
                n_owner = -1; n_ptr = (o + 1) % NR;
            end
        end else if (!ov) begin
            n_idle = m_idle + 1;
        end
        acc = wr_e ? o : -1;
        @(posedge clk);
        #1;
        cyc++;
        m_owner = n_owner; m_ptr = n_ptr; m_idle = n_idle;
        if (acc == 0) void'(q0.pop_front());
        if (acc == 1) void'(q1.pop_front());
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q0.size() > 0 || q1.size() > 0) && guard < 400) begin
            step();
            guard++;
        end
        check("drain_bound", 32'(guard < 400), 32'd1);
        step();
        step();
    endtask

    initial begin
        rst = 1'b1; tx_rdy = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0;
        repeat (2) @(posedge clk);
        #1;
        step();
        check("reset_tx_data", 32'(tx_data), 32'd0);
        rst = 1'b0;

        // Single 3-byte frame from requester 0
        push(0, 3, 8'hA1, 1'b1);
        drain();

        // Both requesters, 2-byte frames
        push(0, 2, 8'h11, 1'b1);
        push(1, 2, 8'h21, 1'b1);
        drain();

        // Requester 1 held under backpressure for 100 cycles
        push(1, 3, 8'h31, 1'b1);
        tx_rdy = 1'b0;
        repeat (100) step();
        tx_rdy = 1'b1;
        drain();

        // Owner stalls mid-frame; requester 1 pending
        push(0, 1, 8'h41, 1'b0);
        push(1, 2, 8'h51, 1'b1);
        drain();
        check("timeout_gap", 32'(tmo_gap), 32'(STALL_LIMIT));

        // Reset on the 2nd of 4 bytes
        push(0, 4, 8'h61, 1'b1);
        push(1, 1, 8'h71, 1'b1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drain();

        // Back-to-back single-byte frames
        for (int i = 0; i < 4; i++) begin
            push(0, 1, 8'h80 + 8'(i), 1'b1);
            push(1, 1, 8'h90 + 8'(i), 1'b1);
        end
        drain();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            if (q0.size() < 3 && $urandom_range(0, 3) == 0)
                push(0, int'($urandom_range(1, 4)), 8'($urandom), $urandom_range(0, 7) != 0);
            if (q1.size() < 3 && $urandom_range(0, 3) == 0)
                push(1, int'($urandom_range(1, 4)), 8'($urandom), $urandom_range(0, 7) != 0);
            tx_rdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 39) == 0) mute0 = ~mute0;
            if ($urandom_range(0, 39) == 0) mute1 = ~mute1;
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0; mute0 = 1'b0; mute1 = 1'b0; tx_rdy = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pc_interface_tx_arbiter
`default_nettype wire
